positenc_prod_sum_es3: RTL and testbench
========================================

# positenc_prod_sum_es3

Downstream output stage of the es=3 product-sum adder. Takes the adder's raw serialized sum (sign, scale, normalized fraction, inf/zero flags) plus its `truncated` flag and produces a packed NBITS-wide posit with es=3. Applies regime/exponent encoding, round-to-nearest-even with sticky, posit saturation and sign. Implemented as a 3-stage elastic pipeline with valid/ready backpressure, so accumulator or writeback logic can stall it.

## Interface
- NBITS, 32: output posit width (supported 8..32).
- ES, 3: exponent size; fixed at 3, elaborated for documentation only.
- SUMW, 70: raw sum width; fields: sgn[69], scale[68:59] (signed), fraction[58:2] (57 bits below hidden bit, MSB-first), inf[1], zero[0].

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_sum  in  SUMW  raw sum from the adder (`result`).
- in_truncated  in  1  adder `truncated`; treated as sticky below fraction LSB.
- in_valid  in  1  in_sum/in_truncated valid (adder `done`).
- in_ready  out  1  stage accepts input this cycle.
- out_posit  out  NBITS  encoded posit.
- out_inexact  out  1  result differs from exact input value.
- out_valid  out  1  out_posit valid.
- out_ready  in  1  consumer accepts output.

## Operation
- Special cases (priority): inf=1 → out_posit = 1 followed by NBITS-1 zeros (NaR), inexact=0. Else zero=1 → 0, inexact=0.
- Decode: k = scale >>> 3 (arithmetic), e = scale[2:0].
- Regime: k≥0 → k+1 ones then a 0; k<0 → −k zeros then a 1.
- Magnitude string = {regime, e, fraction, in_truncated-as-sticky}; top NBITS-1 bits = magnitude; next bit = guard; OR of everything below = sticky.
- Saturation before rounding: k ≥ NBITS-2 → magnitude all ones (maxpos); k < −(NBITS-2) → magnitude 1 (minpos). Saturated result sets inexact.
- Round (macro on): increment when guard & (lsb | sticky). Increment from maxpos clamps to maxpos (never NaR). Zero magnitude from nonzero input becomes minpos (never zero).
- inexact = guard | sticky | saturated.
- Sign: sgn=1 → out_posit = two's complement of {0, magnitude}; else {0, magnitude}.
- Stages: S1 special detect, k/e decode, regime length; S2 barrel shift, guard/sticky extract, saturation; S3 round, clamp, negate, output register.

## Timing
- Latency 3 cycles from accepted input to out_valid when out_ready held high; throughput 1/cycle.
- adv = ~out_valid | out_ready; in_ready = adv (combinational from out_ready). All stages advance together on adv; bubbles are not collapsed.
- Input accepted on cycle with in_valid & in_ready. out_posit/out_inexact held stable while out_valid & ~out_ready.
- Stage valid bits clear on reset; data registers need no reset.
- Reset values: out_valid=0, out_posit=0, out_inexact=0; in_ready=1 in the cycle after reset deasserts.
- Reset mid-operation: all in-flight results dropped; nothing emitted for them.
- Simultaneous in_valid and output stall: input held off (in_ready=0), upstream must hold in_sum stable.

## Configuration
- POSITENC_ROUND_NEAREST_EN defined: round-to-nearest-even as above.
- Undefined: truncation toward zero of magnitude (no increment); saturation, minpos/NaR rules and inexact flag unchanged; latency unchanged.

## Test plan
- Basics (NBITS=32): scale=0, frac=0, sgn=0 → 0x40000000; sgn=1 → 0xC0000000; scale=8 → 0x60000000; scale=−8 → 0x20000000; all inexact=0, out_valid exactly 3 cycles after in_valid.
- Specials: inf=1 → 0x80000000; zero=1 → 0x00000000; zero=1 & inf=1 → 0x80000000.
- Saturation: scale=300 → 0x7FFFFFFF, inexact=1; scale=−300 → 0x00000001, inexact=1; sgn=1, scale=300 → 0x80000001.
- Rounding (macro on): scale=0, fraction=1<<30, truncated=0 → 0x40000000 (tie to even), inexact=1; same with truncated=1 → 0x40000001; fraction all ones at scale=247 → 0x7FFFFFFF. Macro off: both → 0x40000000.
- Backpressure: 8 back-to-back inputs, out_ready toggled 1,0,0,1… → 8 outputs in order, no loss/duplication, output stable while stalled, in_ready low while stalled with out_valid=1.
- Reset: rst_n low 1 cycle with 3 items in flight → out_valid=0 next cycle, no stale output afterwards, next input emerges after 3 cycles.

Source files
------------

// File: rtl/positenc_prod_sum_es3_if.sv
// Handshake bundle between the es=3 product-sum adder, the posit encoder and its consumer.
// master drives the raw sum and out_ready; slave is the encoder side.
interface positenc_prod_sum_es3_if #(
  parameter int NBITS = 32,
  parameter int SUMW  = 70
);
  logic [SUMW-1:0]  in_sum;
  logic             in_truncated;
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] out_posit;
  logic             out_inexact;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_sum, in_truncated, in_valid, out_ready,
    input  in_ready, out_posit, out_inexact, out_valid
  );

  modport slave (
    input  in_sum, in_truncated, in_valid, out_ready,
    output in_ready, out_posit, out_inexact, out_valid
  );
endinterface

// File: rtl/positenc_prod_sum_es3.sv
// es=3 posit output encoder: 3-stage elastic pipeline (decode, shift/saturate, round/negate).
// Define POSITENC_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the magnitude truncates.
module positenc_prod_sum_es3 #(
  parameter int NBITS = 32,
  parameter int ES    = 3,
  parameter int SUMW  = 70
) (
  input logic                     clk,
  input logic                     rst_n,
  positenc_prod_sum_es3_if.slave  bus
);

  localparam int SW  = 10;               // signed scale width
  localparam int FW  = SUMW - 3 - SW;    // fraction bits below the hidden bit
  localparam int SHW = SW - ES;          // enough bits for |k|
  localparam int MW  = NBITS - 1;        // magnitude width (posit minus sign)
  localparam int TW  = 2 + ES + FW + 1 + NBITS;

  // ---------------- handshake ----------------
  logic v1, v2, v3;
  logic adv;

  assign adv          = ~v3 | bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = v3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (adv) begin
      // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
      v1 <= bus.in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // ---------------- S1: special detect, k/e decode, regime run ----------------
  logic              in_sgn, in_inf, in_zero;
  logic [SW-1:0]     in_scale;
  logic [FW-1:0]     in_frac;
  logic signed [31:0] k_wide;
  logic [SHW-1:0]    shamt_d;
  logic              sat_hi_d, sat_lo_d;

  assign in_sgn   = bus.in_sum[SUMW-1];
  assign in_scale = bus.in_sum[SUMW-2 -: SW];
  assign in_frac  = bus.in_sum[FW+1:2];
  assign in_inf   = bus.in_sum[1];
  assign in_zero  = bus.in_sum[0];

  always_comb begin
    // NOTE: every always_comb output gets a value up front so no latch can be inferred.
    k_wide   = $signed({{(32-SW){in_scale[SW-1]}}, in_scale}) >>> ES;
    // Regime run beyond the first bit: k for k>=0, -k-1 for k<0.
    shamt_d  = k_wide[31] ? SHW'(~k_wide) : SHW'(k_wide);
    sat_hi_d = k_wide >= NBITS - 2;
    sat_lo_d = k_wide < -(NBITS - 2);
  end

  logic           s1_nar, s1_zero, s1_sgn, s1_pos, s1_sat_hi, s1_sat_lo, s1_trunc;
  logic [SHW-1:0] s1_shamt;
  logic [ES-1:0]  s1_e;
  logic [FW-1:0]  s1_frac;

  // NOTE: datapath registers carry no reset; the stage valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_nar    <= in_inf;
      s1_zero   <= in_zero;
      s1_sgn    <= in_sgn;
      s1_pos    <= ~k_wide[31];
      s1_shamt  <= shamt_d;
      s1_sat_hi <= sat_hi_d;
      s1_sat_lo <= sat_lo_d;
      s1_e      <= in_scale[ES-1:0];
      s1_frac   <= in_frac;
      s1_trunc  <= bus.in_truncated;
    end
  end

  // ---------------- S2: barrel shift, guard/sticky, saturation ----------------
  logic signed [TW-1:0] seed;
  logic signed [TW-1:0] shifted;
  logic [MW-1:0]        mag_d;
  logic                 guard_d, sticky_d, sat_d;

  always_comb begin
    // Seed starts with the regime's first bit and terminator; the arithmetic
    // shift replicates the first bit to extend the run.
    seed     = {s1_pos, ~s1_pos, s1_e, s1_frac, s1_trunc, {NBITS{1'b0}}};
    shifted  = seed >>> s1_shamt;
    mag_d    = shifted[TW-1 -: MW];
    guard_d  = shifted[TW-NBITS];
    sticky_d = |shifted[TW-NBITS-1:0];
    sat_d    = 1'b0;
    if (s1_sat_hi) begin
      mag_d    = {MW{1'b1}};
      guard_d  = 1'b0;
      sticky_d = 1'b0;
      sat_d    = 1'b1;
    end else if (s1_sat_lo) begin
      mag_d    = {{(MW-1){1'b0}}, 1'b1};
      guard_d  = 1'b0;
      sticky_d = 1'b0;
      sat_d    = 1'b1;
    end
  end

  logic          s2_nar, s2_zero, s2_sgn, s2_guard, s2_sticky, s2_sat;
  logic [MW-1:0] s2_mag;

  always_ff @(posedge clk) begin
    if (adv) begin
      s2_nar    <= s1_nar;
      s2_zero   <= s1_zero;
      s2_sgn    <= s1_sgn;
      s2_mag    <= mag_d;
      s2_guard  <= guard_d;
      s2_sticky <= sticky_d;
      s2_sat    <= sat_d;
    end
  end

  // ---------------- S3: round, clamp, negate ----------------
  logic             inc;
  logic [MW-1:0]    mag_r;
  logic [NBITS-1:0] unsigned_p;
  logic [NBITS-1:0] posit_d;
  logic             inexact_d;

  always_comb begin
    inc = 1'b0;
`ifdef POSITENC_ROUND_NEAREST_EN
    inc = s2_guard & (s2_mag[0] | s2_sticky);
`endif
    // Rounding up from maxpos would wrap into NaR, so it stays at maxpos.
    mag_r = (&s2_mag) ? s2_mag : s2_mag + {{(MW-1){1'b0}}, inc};
    if (mag_r == '0) mag_r = {{(MW-1){1'b0}}, 1'b1};
    unsigned_p = {1'b0, mag_r};
    posit_d    = s2_sgn ? -unsigned_p : unsigned_p;
    inexact_d  = s2_guard | s2_sticky | s2_sat;
    if (s2_nar) begin
      posit_d   = {1'b1, {(NBITS-1){1'b0}}};
      inexact_d = 1'b0;
    end else if (s2_zero) begin
      posit_d   = '0;
      inexact_d = 1'b0;
    end
  end

  logic [NBITS-1:0] posit_q;
  logic             inexact_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      posit_q   <= '0;
      inexact_q <= 1'b0;
    end else if (adv) begin
      posit_q   <= posit_d;
      inexact_q <= inexact_d;
    end
  end

  assign bus.out_posit   = posit_q;
  assign bus.out_inexact = inexact_q;

endmodule

// File: tb/tb_positenc_prod_sum_es3.sv
// Directed self-checking bench for positenc_prod_sum_es3 (NBITS=32): specials, encoding,
// saturation, rounding, backpressure and mid-flight reset.
module tb_positenc_prod_sum_es3;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  positenc_prod_sum_es3_if #(.NBITS(32), .SUMW(70)) bus ();

  positenc_prod_sum_es3 #(.NBITS(32), .ES(3), .SUMW(70)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [69:0] mk(input logic sgn, input int scale, input logic [56:0] frac,
                                     input logic inf, input logic zero);
    return {sgn, 10'(scale), frac, inf, zero};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the pipeline empty.
  task automatic send(input string tag, input logic [69:0] sum, input logic trunc,
                      input logic [31:0] exp_p, input logic exp_x);
    int n;
    bus.in_sum       = sum;
    bus.in_truncated = trunc;
    bus.in_valid     = 1'b1;
    bus.out_ready    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd3);
    check({tag, " posit"}, bus.out_posit, exp_p);
    check({tag, " inexact"}, {31'b0, bus.out_inexact}, {31'b0, exp_x});
    @(posedge clk); #1;
  endtask

  logic [31:0] bp_exp [8] = '{32'h40000000, 32'h60000000, 32'h70000000, 32'h78000000,
                              32'h7C000000, 32'h7E000000, 32'h7F000000, 32'h7F800000};
  int          sent, rcv;
  logic        held, acc_in;
  logic [31:0] held_val;
  logic [31:0] exp_t1, exp_rnd;

  initial begin
`ifdef POSITENC_ROUND_NEAREST_EN
    exp_t1  = 32'h40000001;
    exp_rnd = 32'h40000002;
`else
    exp_t1  = 32'h40000000;
    exp_rnd = 32'h40000001;
`endif
    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_sum       = '0;
    bus.in_truncated = 1'b0;
    bus.out_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("reset out_posit", bus.out_posit, 32'd0);
    check("reset out_inexact", {31'b0, bus.out_inexact}, 32'd0);
    check("reset in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Basic encodings
    send("one",      mk(1'b0,  0, '0, 1'b0, 1'b0), 1'b0, 32'h40000000, 1'b0);
    send("neg one",  mk(1'b1,  0, '0, 1'b0, 1'b0), 1'b0, 32'hC0000000, 1'b0);
    send("k=1",      mk(1'b0,  8, '0, 1'b0, 1'b0), 1'b0, 32'h60000000, 1'b0);
    send("k=-1",     mk(1'b0, -8, '0, 1'b0, 1'b0), 1'b0, 32'h20000000, 1'b0);
    send("neg k=-1", mk(1'b1, -8, '0, 1'b0, 1'b0), 1'b0, 32'hE0000000, 1'b0);
    send("e=5",      mk(1'b0,  5, '0, 1'b0, 1'b0), 1'b0, 32'h54000000, 1'b0);
    send("scale-3",  mk(1'b0, -3, '0, 1'b0, 1'b0), 1'b0, 32'h34000000, 1'b0);

    // Specials
    send("inf",      mk(1'b0, 0, '0, 1'b1, 1'b0), 1'b0, 32'h80000000, 1'b0);
    send("zero",     mk(1'b1, 0, '0, 1'b0, 1'b1), 1'b0, 32'h00000000, 1'b0);
    send("inf+zero", mk(1'b0, 0, '0, 1'b1, 1'b1), 1'b0, 32'h80000000, 1'b0);

    // Saturation and regime boundaries
    send("sat hi",     mk(1'b0,  300, '0, 1'b0, 1'b0), 1'b0, 32'h7FFFFFFF, 1'b1);
    send("sat lo",     mk(1'b0, -300, '0, 1'b0, 1'b0), 1'b0, 32'h00000001, 1'b1);
    send("neg sat hi", mk(1'b1,  300, '0, 1'b0, 1'b0), 1'b0, 32'h80000001, 1'b1);
    send("k=29",       mk(1'b0,  232, '0, 1'b0, 1'b0), 1'b0, 32'h7FFFFFFE, 1'b0);
    send("k=-30",      mk(1'b0, -240, '0, 1'b0, 1'b0), 1'b0, 32'h00000001, 1'b0);

    // Rounding
    send("tie even",   mk(1'b0, 0, 57'h40000000, 1'b0, 1'b0), 1'b0, 32'h40000000, 1'b1);
    send("tie sticky", mk(1'b0, 0, 57'h40000000, 1'b0, 1'b0), 1'b1, exp_t1,       1'b1);
    send("odd up",     mk(1'b0, 0, 57'hC0000000, 1'b0, 1'b0), 1'b0, exp_rnd,      1'b1);
    send("sticky only",mk(1'b0, 0, 57'h1,        1'b0, 1'b0), 1'b0, 32'h40000000, 1'b1);
    send("max frac",   mk(1'b0, 247, {57{1'b1}}, 1'b0, 1'b0), 1'b0, 32'h7FFFFFFF, 1'b1);

    // Backpressure: 8 back-to-back items, out_ready pattern 1,0,0,1
    sent = 0; rcv = 0; held = 1'b0; held_val = '0;
    for (int cyc = 0; cyc < 80 && rcv < 8; cyc++) begin
      bus.out_ready    = (cyc % 4 == 0) || (cyc % 4 == 3);
      bus.in_valid     = (sent < 8);
      bus.in_sum       = mk(1'b0, 8 * ((sent < 8) ? sent : 7), '0, 1'b0, 1'b0);
      bus.in_truncated = 1'b0;
      @(negedge clk);
      if (held) begin
        check("bp stall valid", {31'b0, bus.out_valid}, 32'd1);
        check("bp stall posit", bus.out_posit, held_val);
      end
      if (bus.out_valid && !bus.out_ready)
        check("bp in_ready stall", {31'b0, bus.in_ready}, 32'd0);
      held     = bus.out_valid && !bus.out_ready;
      held_val = bus.out_posit;
      acc_in   = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        check("bp order", bus.out_posit, bp_exp[rcv]);
        rcv++;
      end
      @(posedge clk); #1;
      if (acc_in) sent++;
    end
    check("bp received", 32'(rcv), 32'd8);
    check("bp sent", 32'(sent), 32'd8);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp no extra", {31'b0, bus.out_valid}, 32'd0);
    end
    @(posedge clk); #1;

    // Reset with three items in flight
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sum   = mk(1'b0, 8 * i, '0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    @(posedge clk); #1;
    check("rst mid out_valid", {31'b0, bus.out_valid}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("rst no stale", {31'b0, bus.out_valid}, 32'd0);
    end
    send("post reset", mk(1'b0, 8, '0, 1'b0, 1'b0), 1'b0, 32'h60000000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
